// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Build option: define UART_RX_PARITY_EN to add the PARITY state (8E1 frames).
package uart_pkg;

  localparam int DEFAULT_WAIT = 868;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    IDLE     = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY   = 3'd5
`endif
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a flop-based store; head entry is read straight from flops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: centre-samples 8N1 frames and queues bytes behind a valid/ready port.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a live parity_err pulse.
// Handshake: a byte is popped on any rising clk edge where rx_valid && rx_ready;
// rx_data holds while rx_valid && !rx_ready.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WAIT  = DEFAULT_WAIT,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  output rx_state_e         dbg_state
);

  localparam int CNT_W = $clog2(WAIT);
  localparam int FCW   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(WAIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(WAIT - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bad_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              bit_tick;
  logic              push;
  logic              pop_fire;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;

  // The start bit is sampled half a period in; every later bit a full period after the last.
  assign bit_tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);
  assign push     = (state_q == STOP) && bit_tick && uart_rx && !par_bad_q;
  assign pop_fire = rx_ready && (fifo_count != '0);
  assign drop     = push && fifo_full && !pop_fire;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= DISARMED;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= drop;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        DISARMED: if (uart_rx) state_q <= IDLE;
        IDLE: begin
          if (!uart_rx) begin
            state_q   <= START;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            par_bad_q <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            state_q <= uart_rx ? IDLE : DATA;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        DATA: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            shift_q   <= {uart_rx, shift_q[DATA_W-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == 3'd7) state_q <= PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= STOP;
`endif
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_bad_q <= (uart_rx != even_parity(shift_q));
            state_q   <= STOP;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
`endif
        STOP: begin
          // Return to IDLE mid-stop so a start bit right after the stop bit is caught.
          if (bit_tick) begin
            cnt_q        <= '0;
            frame_err_q  <= !uart_rx;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_bad_q;
`endif
            state_q      <= IDLE;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        default: state_q <= DISARMED;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .n_reset(n_reset),
    .push   (push),
    .pop    (rx_ready),
    .wr_data(shift_q),
    .rd_data(rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with WAIT=16, DEPTH=16.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int W = 16;
  localparam int D = 16;
  localparam int H = W / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int S = H + (NB - 1) * W;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  rx_state_e  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic       obs_pre_valid, obs_valid, obs_ferr, obs_perr, obs_ovr;
  logic       obs_ferr2, obs_perr2, obs_ovr2, obs_early;
  logic [7:0] obs_data;

  uart_rx_fifo #(.WAIT(W), .DEPTH(D)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .dbg_state (dbg_state)
  );

  // Clock and pop monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n_reset && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic bad_par, input logic pop_at_stop);
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ bad_par;
    bits[10] = stop_v;
`else
    bits[9]  = stop_v;
`endif
    obs_early = 1'b0;
    for (int k = 0; k < NB * W; k++) begin
      uart_rx = bits[k / W];
      if (k < S) obs_early = obs_early | frame_err | parity_err | overrun;
      if (k == S) begin
        obs_pre_valid = rx_valid;
        if (pop_at_stop) rx_ready = 1'b1;
      end
      if (k == S + 1) begin
        obs_valid = rx_valid;
        obs_data  = rx_data;
        obs_ferr  = frame_err;
        obs_perr  = parity_err;
        obs_ovr   = overrun;
        if (pop_at_stop) rx_ready = 1'b0;
      end
      if (k == S + 2) begin
        obs_ferr2 = frame_err;
        obs_perr2 = parity_err;
        obs_ovr2  = overrun;
      end
      tick();
    end
    uart_rx = 1'b1;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < D + 4; i++) begin
      if (!rx_valid) break;
      tick();
    end
    rx_ready = 1'b0;
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout rx_valid=%b want 0", rx_valid);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    n_reset = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_vec++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {frame_err, overrun, parity_err}); end
    n_vec++; if (dbg_state !== DISARMED) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, DISARMED); end
    n_reset = 1'b1;
    tick();
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL arm_state got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_single_byte();
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    n_vec++; if (obs_pre_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", obs_pre_valid); end
    n_vec++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", obs_valid); end
    n_vec++; if (obs_data !== 8'h55) begin n_err++; $display("FAIL single_data got %h want 55", obs_data); end
    n_vec++; if ({obs_ferr, obs_perr, obs_ovr, obs_early} !== 4'b0000) begin n_err++; $display("FAIL single_pulses got %b want 0000", {obs_ferr, obs_perr, obs_ovr, obs_early}); end
    n_vec++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL single_hold got %h want 55", rx_data); end
    exp_q = '{8'h55};
    drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_pop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b1;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    n_vec++; if (obs_data !== 8'hA3) begin n_err++; $display("FAIL b2b_first_data got %h want a3", obs_data); end
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    rx_ready = 1'b0;
    exp_q = '{8'hA3, 8'h00};
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_pop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", rx_valid); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    uart_rx = 1'b0;
    tick();
    n_vec++; if (dbg_state !== START) begin n_err++; $display("FAIL glitch_start got %0d want %0d", dbg_state, START); end
    repeat (W / 4 - 1) tick();
    uart_rx = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      seen = seen | frame_err | parity_err | overrun | rx_valid;
      tick();
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_activity got %b want 0", seen); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL glitch_state got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_frame_error();
    logic seen;
    seen = 1'b0;
    rx_ready = 1'b0;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    n_vec++; if (obs_ferr !== 1'b1) begin n_err++; $display("FAIL ferr_pulse got %b want 1", obs_ferr); end
    n_vec++; if (obs_ferr2 !== 1'b0) begin n_err++; $display("FAIL ferr_width got %b want 0", obs_ferr2); end
    n_vec++; if ({obs_perr, obs_ovr, obs_early} !== 3'b000) begin n_err++; $display("FAIL ferr_other got %b want 000", {obs_perr, obs_ovr, obs_early}); end
    n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid got %b want 0", obs_valid); end
    for (int i = 0; i < 2 * W; i++) begin
      seen = seen | rx_valid | frame_err;
      tick();
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL ferr_after got %b want 0", seen); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL ferr_state got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_overrun();
    logic ovr_seen;
    rx_ready = 1'b0;
    ovr_seen = 1'b0;
    for (int b = 0; b < D; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, 1'b0);
      ovr_seen = ovr_seen | obs_ovr;
      exp_q.push_back(8'(b));
    end
    n_vec++; if (ovr_seen !== 1'b0) begin n_err++; $display("FAIL ovr_early got %b want 0", ovr_seen); end
    send_frame(8'h10, 1'b1, 1'b0, 1'b0);
    n_vec++; if (obs_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_pulse got %b want 1", obs_ovr); end
    n_vec++; if (obs_ovr2 !== 1'b0) begin n_err++; $display("FAIL ovr_width got %b want 0", obs_ovr2); end
    n_vec++; if (obs_data !== 8'h00) begin n_err++; $display("FAIL ovr_head got %h want 00", obs_data); end
    drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr_pop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();

    for (int b = 0; b < D; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'(b));
    end
    send_frame(8'h10, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(8'h10);
    n_vec++; if (obs_ovr !== 1'b0) begin n_err++; $display("FAIL popov_pulse got %b want 0", obs_ovr); end
    drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL popov_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL popov_pop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rst_preload got %b want 1", rx_valid); end
    uart_rx = 1'b0;
    repeat (W + H) tick();
    n_reset = 1'b0;
    #1;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", rx_valid); end
    n_vec++; if (dbg_state !== DISARMED) begin n_err++; $display("FAIL rst_async_state got %0d want %0d", dbg_state, DISARMED); end
    repeat (5) tick();
    n_reset = 1'b1;
    repeat (3 * W) tick();
    n_vec++; if (dbg_state !== DISARMED) begin n_err++; $display("FAIL rst_low_state got %0d want %0d", dbg_state, DISARMED); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_low_valid got %b want 0", rx_valid); end
    uart_rx = 1'b1;
    repeat (2) tick();
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_rearm got %0d want %0d", dbg_state, IDLE); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    n_vec++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL rst_byte_valid got %b want 1", obs_valid); end
    n_vec++; if (obs_data !== 8'h3C) begin n_err++; $display("FAIL rst_byte_data got %h want 3c", obs_data); end
    exp_q = '{8'h3C};
    drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rst_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_pop[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    n_vec++; if (obs_perr !== 1'b1) begin n_err++; $display("FAIL par_pulse got %b want 1", obs_perr); end
    n_vec++; if (obs_perr2 !== 1'b0) begin n_err++; $display("FAIL par_width got %b want 0", obs_perr2); end
    n_vec++; if (obs_ferr !== 1'b0) begin n_err++; $display("FAIL par_ferr got %b want 0", obs_ferr); end
    n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL par_valid got %b want 0", obs_valid); end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    n_vec++; if ({obs_ferr, obs_perr, obs_valid} !== 3'b110) begin n_err++; $display("FAIL par_both got %b want 110", {obs_ferr, obs_perr, obs_valid}); end
    uart_rx = 1'b1;
    repeat (2 * W) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive side of the board's UART link: recovers 8N1 frames from the (already synchronized) `uart_rx` line, samples each bit at its centre, and buffers received bytes in a small FIFO exposed through a valid/ready interface. It sits between the board-level pin synchronizers and the consumer logic in the mother board. It reports framing and overrun events as single-cycle pulses.

## Interface
- `WAIT`, 868, clock cycles per bit (CLOCK_HZ/UART_BAUD_RATE; 100 MHz / 115200)
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `clk`  in  1  system clock
- `n_reset`  in  1  asynchronous, active-low reset
- `uart_rx`  in  1  serial input, already two-flop synchronized upstream; idle high
- `rx_data`  out  8  byte at FIFO head
- `rx_valid`  out  1  FIFO non-empty
- `rx_ready`  in  1  consumer pop; pop occurs on `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: byte completed while FIFO full, byte dropped
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 when parity compiled out)

## Operation
- FSM states: DISARMED, IDLE, START, DATA, PARITY (only with macro), STOP.
- DISARMED: entered on reset; moves to IDLE on first cycle `uart_rx`==1. Prevents a line held low through reset from being decoded as a start bit.
- IDLE: `uart_rx`==0 → START, bit counter cleared.
- START: after WAIT/2 (integer division) cycles sample; 0 → DATA; 1 → IDLE (glitch rejected, no pulse).
- DATA: sample every WAIT cycles, LSB first, into shift register; after bit 7 → PARITY or STOP.
- PARITY: sample after WAIT; compare against even parity of the 8 data bits; mismatch sets internal flag.
- STOP: sample after WAIT; 1 and no parity flag → push byte; 0 → `frame_err`, no push; parity flag with stop 1 → `parity_err`, no push; both faults → both pulses, no push. Always → IDLE on the sample cycle (not end of stop bit), so back-to-back frames are caught.
- Push when FIFO full and no simultaneous pop → byte dropped, `overrun` pulses. Full with pop in the same cycle → push accepted.
- Bit-period counter width $clog2(WAIT); bit index 3 bits; FIFO count width $clog2(DEPTH+1); pointers $clog2(DEPTH) bits, natural wrap.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0; FSM DISARMED; FIFO empty.
- t0 = first cycle `uart_rx`==0 seen in IDLE. Start sample at t0+WAIT/2; data bit i at t0+WAIT/2+(i+1)·WAIT; stop at t0+WAIT/2+9·WAIT (10·WAIT with parity).
- Push on stop-sample cycle; `rx_valid`/`rx_data` update the following cycle (1-cycle latency, registered FIFO output).
- Error pulses asserted the cycle after the stop sample, exactly one cycle wide.
- Pop: `rx_data` advances / `rx_valid` falls the cycle after the pop edge. `rx_data` stable while `rx_valid && !rx_ready`.
- Reset asserted mid-frame: partial byte discarded, FIFO cleared immediately (async).

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1, PARITY state present, `parity_err` live.
- Not defined: frame is 8N1, PARITY state absent, `parity_err` tied 0; port list unchanged.

## Structure
- Package `uart_pkg`: FSM state enum, `DEFAULT_WAIT` (868), data width constant 8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated once; the receiver FSM and bit timing stay in `uart_rx_fifo`.

## Test plan
- WAIT=16; send 0x55 8N1, `rx_ready`=0 → `rx_valid`=1, `rx_data`=0x55 one cycle after stop sample; no error pulses.
- Back-to-back 0xA3, 0x00 with stop bit exactly one period → both bytes popped in order with `rx_ready`=1.
- `uart_rx` low for WAIT/4 then high → no push, no pulses, FSM back in IDLE.
- Send 0x7E with stop bit 0 → `frame_err` one-cycle pulse, `rx_valid` stays 0.
- `rx_ready`=0, send DEPTH+1 bytes (0x00..0x10) → 17th raises `overrun`; pops return 0x00..0x0F; repeat with pop coinciding with 17th push → no overrun, 0x10 stored.
- Assert `n_reset` low mid-byte while line low, release with line low, then send 0x3C → no spurious byte; 0x3C received; with `UART_RX_PARITY_EN`, 0x3C with odd parity bit → `parity_err`, no push.
